// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared types and constants for the PS/2 mouse tracker:
//   pkt_state_t   packet assembly states (B0 header, B1 dx, B2 dy)
//   hdr_t         the header-byte fields kept between bytes of a packet
//   FRAME_BITS    bits per PS/2 device frame
//   BTN_L..YOVF   bit positions inside the header byte
//   clamp12       saturates a signed 12-bit sum into 0..max
package ps2_pkg;

  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2
  } pkt_state_t;

  localparam int FRAME_BITS = 11;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int ALIGN = 3;
  localparam int XSIGN = 4;
  localparam int YSIGN = 5;
  localparam int XOVF  = 6;
  localparam int YOVF  = 7;

  typedef struct packed {
    logic yovf;
    logic xovf;
    logic ysign;
    logic xsign;
    logic btnr;
    logic btnl;
  } hdr_t;

  function automatic logic [11:0] clamp12(input logic signed [11:0] v,
                                          input logic        [11:0] mx);
    if (v < 12'sd0) return 12'd0;
    if (v > $signed(mx)) return mx;
    return v;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// ps2_rx
// PS/2 device-to-host frame receiver: 2-FF synchronisers on clock and data,
// a debounce on the clock line, a falling-edge bit shifter, and an idle
// timeout that discards partial frames.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   ps2c/ps2d  raw asynchronous PS/2 clock and data
//   data       received byte, valid while strobe is high
//   strobe     one-cycle pulse per accepted frame
//   frame_err  one-cycle pulse for a frame rejected on parity/stop
//   timeout    one-cycle pulse when the line has been idle too long
//
// Build option: define PS2_PARITY_CHECK_EN to reject frames with bad odd
// parity or a zero stop bit; otherwise every complete frame is accepted.
module ps2_rx #(
  parameter int DEB_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] data,
  output logic       strobe,
  output logic       frame_err,
  output logic       timeout
);
  import ps2_pkg::*;

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DW-1:0] DEB_RELOAD  = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] IDLE_RELOAD = TW'(TIMEOUT_CYCLES);
  localparam logic [3:0]    LAST_BIT    = 4'(FRAME_BITS - 1);

  logic [1:0]    c_sync, d_sync;
  logic          c_deb, fall, d;
  logic [DW-1:0] deb_cnt;
  logic [TW-1:0] idle_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          frame_ok;

  assign d = d_sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      c_sync <= 2'b11;
      d_sync <= 2'b11;
    end else begin
      c_sync <= {c_sync[0], ps2c};
      d_sync <= {d_sync[0], ps2d};
    end
  end

  // Debounce: the counter reloads while the synced level matches the
  // accepted level and runs down while it differs, so a new level is taken
  // only after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_deb   <= 1'b1;
      deb_cnt <= DEB_RELOAD;
      fall    <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (c_sync[1] == c_deb) begin
        deb_cnt <= DEB_RELOAD;
      end else if (deb_cnt == '0) begin
        c_deb   <= c_sync[1];
        deb_cnt <= DEB_RELOAD;
        fall    <= c_deb;
      end else begin
        deb_cnt <= deb_cnt - 1'b1;
      end
    end
  end

  // Idle down-counter: reloaded on every falling edge, terminal count of 1
  // yields exactly one timeout pulse per idle stretch.
  assign timeout = (idle_cnt == TW'(1)) && !fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= IDLE_RELOAD;
    end else if (fall) begin
      idle_cnt <= IDLE_RELOAD;
    end else if (idle_cnt != '0) begin
      idle_cnt <= idle_cnt - 1'b1;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_bit <= 1'b0;
    end else if (fall && bit_cnt == 4'd9) begin
      par_bit <= d;
    end
  end

  // d is the stop bit at the moment frame_ok is consulted.
  assign frame_ok = (^{shreg, par_bit}) && d;
`else
  assign frame_ok = 1'b1;
`endif

  // bit_cnt: 0 idle/start, 1..8 data, 9 parity, 10 stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= 4'd0;
      shreg     <= 8'd0;
      data      <= 8'd0;
      strobe    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      strobe    <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        if (bit_cnt == 4'd0) begin
          if (!d) bit_cnt <= 4'd1;
        end else if (bit_cnt <= 4'd8) begin
          shreg   <= {d, shreg[7:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end else if (bit_cnt < LAST_BIT) begin
          bit_cnt <= bit_cnt + 4'd1;
        end else begin
          bit_cnt <= 4'd0;
          if (frame_ok) begin
            data   <= shreg;
            strobe <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end
      end else if (timeout) begin
        bit_cnt <= 4'd0;
      end
    end
  end

endmodule

// File: rtl/ps2_mouse_tracker.sv
// ps2_mouse_tracker
// Turns a raw PS/2 mouse stream into a clamped absolute crosshair position
// and button levels for the game top level.
//
// Ports:
//   clk        system clock (50 MHz)
//   rst        synchronous active-high reset
//   PS2C/PS2D  raw asynchronous PS/2 clock and data
//   x          absolute x, 0..X_MAX
//   y          absolute y, 0..Y_MAX, screen-down positive
//   btnl/btnr  button levels from the last applied packet
//   pkt_valid  one-cycle pulse on the cycle a packet is applied
//
// Build option: PS2_PARITY_CHECK_EN (see ps2_rx) makes a bad frame drop
// the packet in progress.
//
// Packet FSM:
//   state | meaning
//   B0    | waiting for a header byte with the alignment bit set
//   B1    | header held, waiting for the dx byte
//   B2    | dx held, waiting for the dy byte; its arrival commits
module ps2_mouse_tracker
  import ps2_pkg::*;
#(
  parameter int X_MAX          = 639,
  parameter int Y_MAX          = 255,
  parameter int X_INIT         = 320,
  parameter int Y_INIT         = 128,
  parameter int DEB_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PS2C,
  input  logic       PS2D,
  output logic [9:0] x,
  output logic [7:0] y,
  output logic       btnl,
  output logic       btnr,
  output logic       pkt_valid
);

  logic [7:0] data;
  logic       strobe, frame_err, timeout;

  ps2_rx #(
    .DEB_CYCLES    (DEB_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .ps2c     (PS2C),
    .ps2d     (PS2D),
    .data     (data),
    .strobe   (strobe),
    .frame_err(frame_err),
    .timeout  (timeout)
  );

  pkt_state_t state, state_n;
  logic       cap_hdr, cap_dx, commit;
  hdr_t       hdr;
  logic [7:0] dxbyte;

  always_ff @(posedge clk) begin
    if (rst) state <= B0;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    cap_hdr = 1'b0;
    cap_dx  = 1'b0;
    commit  = 1'b0;
    if (frame_err || timeout) begin
      state_n = B0;
    end else if (strobe) begin
      case (state)
        B0: begin
          // Bytes without the alignment bit cannot be a header: drop them
          // so the stream re-locks onto the next real header.
          if (data[ALIGN]) begin
            cap_hdr = 1'b1;
            state_n = B1;
          end
        end
        B1: begin
          cap_dx  = 1'b1;
          state_n = B2;
        end
        B2: begin
          commit  = 1'b1;
          state_n = B0;
        end
        default: state_n = B0;
      endcase
    end
  end

  // Deltas are 9-bit two's complement; an overflowed axis contributes 0.
  // The dy byte is taken straight from the receiver on the commit cycle.
  logic        [8:0]  dx, dy;
  logic signed [11:0] x_sum, y_sum;

  always_comb begin
    dx    = hdr.xovf ? 9'd0 : {hdr.xsign, dxbyte};
    dy    = hdr.yovf ? 9'd0 : {hdr.ysign, data};
    x_sum = $signed({2'b00, x}) + $signed({{3{dx[8]}}, dx});
    y_sum = $signed({4'b0000, y}) - $signed({{3{dy[8]}}, dy});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x         <= 10'(X_INIT);
      y         <= 8'(Y_INIT);
      btnl      <= 1'b0;
      btnr      <= 1'b0;
      pkt_valid <= 1'b0;
      hdr       <= '0;
      dxbyte    <= 8'd0;
    end else begin
      pkt_valid <= commit;
      if (cap_hdr) begin
        hdr <= '{yovf:  data[YOVF],  xovf:  data[XOVF],
                 ysign: data[YSIGN], xsign: data[XSIGN],
                 btnr:  data[BTN_R], btnl:  data[BTN_L]};
      end
      if (cap_dx) dxbyte <= data;
      if (commit) begin
        x    <= 10'(clamp12(x_sum, 12'(X_MAX)));
        y    <= 8'(clamp12(y_sum, 12'(Y_MAX)));
        btnl <= hdr.btnl;
        btnr <= hdr.btnr;
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
module tb_ps2_mouse_tracker;

  localparam int HALF = 14;

  logic       clk = 1'b0;
  logic       rst;
  logic       PS2C;
  logic       PS2D;
  logic [9:0] x;
  logic [7:0] y;
  logic       btnl, btnr, pkt_valid;

  int n_cmp  = 0;
  int n_err  = 0;
  int pulses = 0;

  int   x_ref, y_ref;
  logic bl_ref, br_ref;

  always #10 clk = ~clk;

  ps2_mouse_tracker dut (
    .clk      (clk),
    .rst      (rst),
    .PS2C     (PS2C),
    .PS2D     (PS2D),
    .x        (x),
    .y        (y),
    .btnl     (btnl),
    .btnr     (btnr),
    .pkt_valid(pkt_valid)
  );

  always @(negedge clk) if (pkt_valid === 1'b1) pulses++;

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int mx);
    if (v < 0) return 0;
    if (v > mx) return mx;
    return v;
  endfunction

  // Reference: apply one stream-mode packet to the position/button model.
  task automatic model_apply(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int dxv, dyv;
    dxv = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
    dyv = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
    x_ref  = clampi(x_ref + dxv, 639);
    y_ref  = clampi(y_ref - dyv, 255);
    bl_ref = b0[0];
    br_ref = b0[1];
  endtask

  task automatic send_bits(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      PS2D = f[i];
      clks(HALF);
      PS2C = 1'b0;
      clks(HALF);
      PS2C = 1'b1;
    end
    PS2D = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    send_bits(f, 11);
    clks(2 * HALF);
  endtask

  task automatic check_state(input string tag, input int npulse);
    chk({tag, "_pulse"}, npulse, 0);
    chk({tag, "_x"}, x, x_ref);
    chk({tag, "_y"}, y, y_ref);
    chk({tag, "_btnl"}, btnl, bl_ref);
    chk({tag, "_btnr"}, btnr, br_ref);
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input bit commit_exp, input string tag);
    int p0;
    p0 = pulses;
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
    clks(4);
    if (commit_exp) model_apply(b0, b1, b2);
    check_state(tag, pulses - p0 - (commit_exp ? 1 : 0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clks(2);
    rst = 1'b0;
    clks(2);
    x_ref  = 320;
    y_ref  = 128;
    bl_ref = 1'b0;
    br_ref = 1'b0;
  endtask

  initial begin
    int p0;
    logic [7:0] b0, b1, b2;

    PS2C = 1'b1;
    PS2D = 1'b1;
    do_reset();
    chk("rst_x", x, 320);
    chk("rst_y", y, 128);
    chk("rst_btnl", btnl, 0);
    chk("rst_btnr", btnr, 0);
    chk("rst_pkt_valid", pkt_valid, 0);

    // Reset in the middle of a packet discards the header already taken.
    p0 = pulses;
    send_byte(8'h09, 1'b0);
    do_reset();
    send_byte(8'h10, 1'b0);
    send_byte(8'h00, 1'b0);
    clks(4);
    check_state("midrst", pulses - p0);

    send_packet(8'h09, 8'h10, 8'h00, 1'b1, "lclick");
    chk("lclick_x_abs", x, 336);
    chk("lclick_btnl_abs", btnl, 1);

    do_reset();
    send_packet(8'h38, 8'hF0, 8'hFB, 1'b1, "leftdown");
    chk("leftdown_x_abs", x, 304);
    chk("leftdown_y_abs", y, 133);

    do_reset();
    send_packet(8'h08, 8'hFF, 8'h00, 1'b1, "to575");
    send_packet(8'h08, 8'h37, 8'h00, 1'b1, "to630");
    chk("x_at_630", x, 630);
    send_packet(8'h08, 8'h32, 8'h00, 1'b1, "xclamp");
    chk("xclamp_abs", x, 639);
    send_packet(8'h08, 8'h00, 8'h7E, 1'b1, "to_y2");
    chk("y_at_2", y, 2);
    send_packet(8'h08, 8'h00, 8'h0A, 1'b1, "yclamp");
    chk("yclamp_abs", y, 0);
    send_packet(8'h48, 8'h7F, 8'h00, 1'b1, "xovf");
    chk("xovf_abs", x, 639);

    // Stray non-header byte followed by a real packet.
    do_reset();
    send_byte(8'h00, 1'b0);
    send_packet(8'h08, 8'h05, 8'h00, 1'b1, "resync");
    chk("resync_x_abs", x, 325);

    // Partial frame, long stall, then a clean packet.
    send_bits(11'b000_0101_0110, 6);
    clks(60000);
    send_packet(8'h08, 8'h03, 8'h02, 1'b1, "timeout");

    // Header with flipped parity.
    p0 = pulses;
    send_byte(8'h08, 1'b1);
    send_byte(8'h05, 1'b0);
    send_byte(8'h00, 1'b0);
    clks(4);
`ifdef PS2_PARITY_CHECK_EN
    check_state("parity", pulses - p0);
`else
    model_apply(8'h08, 8'h05, 8'h00);
    check_state("parity", pulses - p0 - 1);
`endif

    for (int k = 0; k < 6; k++) begin
      b0 = 8'($urandom) | 8'h08;
      if ($urandom_range(0, 3) != 0) b0[7:6] = 2'b00;
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      send_packet(b0, b1, b2, 1'b1, $sformatf("rand%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
